// File: rtl/demux1x16_frame_capture.sv
// demux1x16_frame_capture
// Registered 1-to-16 demultiplexer with frame tracking. Each valid input word
// goes to one of 16 held output lanes. The lane is chosen by s in addressed
// mode or by an internal wrapping pointer in sequential mode. Per-lane
// written flags, their population count and a one-cycle frame completion
// pulse let parallel consumers know when a full set of fresh lanes is ready.

module demux1x16_frame_capture #(
   parameter int DATA_W = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    din,
   input  logic                 din_valid,
   input  logic [3:0]           s,
   input  logic                 mode,
   input  logic                 clr,
   output logic [16*DATA_W-1:0] y,
   output logic [15:0]          y_vld,
   output logic [4:0]           cnt,
   output logic [3:0]           ptr,
   output logic                 frame_done
);

   // Frame tracking state: no lanes flagged, some flagged, all flagged.
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        wr_en;      // a write is committed at the next edge
   logic        seq_wr;     // that write uses the sequential pointer
   logic [3:0]  lane;       // lane targeted by this cycle's write
   logic [15:0] lane_oh;    // one-hot of lane
   logic        lane_new;   // targeted lane is not yet flagged this frame
   logic        last_lane;  // this write sets the final clear flag

   logic [15:0] vld_nxt;
   logic [4:0]  cnt_nxt;
   logic [3:0]  ptr_nxt;
   logic        done_nxt;

   // clr wins over din_valid, so a strobe in a clearing cycle is dropped.
   assign wr_en     = din_valid & ~clr;
   assign seq_wr    = wr_en & mode;
   assign lane      = mode ? ptr : s;
   assign lane_oh   = 16'd1 << lane;
   assign lane_new  = ~|(y_vld & lane_oh);
   assign last_lane = lane_new && (cnt == 5'd15);

   // State register for the frame tracker.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, flag, count and pulse decode for the frame tracker.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      state_nxt = state;
      vld_nxt   = y_vld;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;

      if (clr) begin
         state_nxt = EMPTY;
         vld_nxt   = '0;
         cnt_nxt   = '0;
      end else if (din_valid) begin
         unique case (state)
            EMPTY: begin
               // First write of a frame: exactly one lane becomes flagged.
               state_nxt = PARTIAL;
               vld_nxt   = lane_oh;
               cnt_nxt   = 5'd1;
            end
            PARTIAL: begin
               // Rewrites refresh data only; flags and count move on new lanes.
               vld_nxt = y_vld | lane_oh;
               if (lane_new) begin
                  cnt_nxt = cnt + 5'd1;
               end
               if (last_lane) begin
                  state_nxt = FULL;
                  done_nxt  = 1'b1;
               end
            end
            FULL: begin
               // A write into a complete frame opens the next frame.
               state_nxt = PARTIAL;
               vld_nxt   = lane_oh;
               cnt_nxt   = 5'd1;
            end
            default: begin
               state_nxt = EMPTY;
               vld_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Sequential pointer: advances on sequential-mode writes, wraps 15 -> 0,
   // survives frame completion and addressed-mode traffic.
   always_comb begin
      ptr_nxt = ptr;
      if (clr) begin
         ptr_nxt = '0;
      end else if (seq_wr) begin
         ptr_nxt = ptr + 4'd1;
      end
   end

   // Flag, count, pointer and frame pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_vld      <= '0;
         cnt        <= '0;
         ptr        <= '0;
         frame_done <= 1'b0;
      end else begin
         y_vld      <= vld_nxt;
         cnt        <= cnt_nxt;
         ptr        <= ptr_nxt;
         frame_done <= done_nxt;
      end
   end

   // Lane data registers: only the addressed lane loads; clr leaves data intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the lane storage is reset because consumers must see all-zero lanes while rst is high.
         y <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < 16; k++) begin
            if (lane_oh[k]) begin
               y[k*DATA_W +: DATA_W] <= din;
            end
         end
      end
   end

endmodule
